// File: rtl/sobel_pkg.sv
// +----------------------------------------------------------------------------+
// | sobel_pkg: shared types for the Sobel 3x3 window generator.                 |
// | Revision: 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package sobel_pkg;

  localparam int SOBEL_PIX_W = 8;

  typedef logic [SOBEL_PIX_W-1:0] pix_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } win_state_e;

  // Fixed-width view of one neighbourhood; index [row][col], row 0 = oldest line.
  typedef struct packed {
    pix_t [2:0] top;
    pix_t [2:0] mid;
    pix_t [2:0] bot;
  } win_t;

endpackage

`default_nettype wire

// File: rtl/sobel_line_buf.sv
// +----------------------------------------------------------------------------+
// | sobel_line_buf: one line of pixel storage, registered read, one write.      |
// | Revision: 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module sobel_line_buf #(
  parameter int DEPTH = 640,
  parameter int DW    = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
      r_rd_data        <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/sobel_window_gen.sv
// +----------------------------------------------------------------------------+
// | sobel_window_gen: raster stream to registered 3x3 window with valid strobe. |
// | Optional macro SOBEL_WIN_CENTER_EN exports the centre tap p4.               |
// | Revision: 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = SOBEL_PIX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sof,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_in,
  output logic [PIX_W-1:0] p0,
  output logic [PIX_W-1:0] p1,
  output logic [PIX_W-1:0] p2,
  output logic [PIX_W-1:0] p3,
`ifdef SOBEL_WIN_CENTER_EN
  output logic [PIX_W-1:0] p4,
`endif
  output logic [PIX_W-1:0] p5,
  output logic [PIX_W-1:0] p6,
  output logic [PIX_W-1:0] p7,
  output logic [PIX_W-1:0] p8,
  output logic             win_valid,
  output logic             frame_done,
  output logic             frame_abort
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] c_col_last = CW'(IMG_W - 1);
  localparam logic [RW-1:0] c_row_last = RW'(IMG_H - 1);

  win_state_e r_state, w_state_nxt;
  logic [CW-1:0] r_col, w_col, w_col_nxt;
  logic [RW-1:0] r_row, w_row;
  logic w_restart, w_accept, w_line_end, w_frame_end;
  logic [PIX_W-1:0] w_lb0_q, w_lb1_q;
  logic [2:0][2:0][PIX_W-1:0] r_win;
  logic r_win_valid, r_frame_done, r_frame_abort;

  // A sof pixel is always taken as (0,0), whatever the current position.
  assign w_restart   = pix_valid && sof;
  assign w_accept    = pix_valid && (sof || (r_state != IDLE));
  assign w_col       = w_restart ? '0 : r_col;
  assign w_row       = w_restart ? '0 : r_row;
  assign w_line_end  = (w_col == c_col_last);
  assign w_frame_end = w_line_end && (w_row == c_row_last);
  assign w_col_nxt   = w_line_end ? '0 : w_col + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_restart) begin
      w_state_nxt = FILL;
    end else if (pix_valid) begin
      case (r_state)
        FILL:    if (w_line_end && (w_row == RW'(1))) w_state_nxt = STREAM;
        STREAM:  if (w_frame_end) w_state_nxt = IDLE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_frame_end) begin
        r_col <= '0;
        r_row <= '0;
      end else begin
        r_col <= w_col_nxt;
        r_row <= w_line_end ? w_row + RW'(1) : w_row;
      end
    end
  end

  // Buffers read one column ahead so their registered output lines up with the
  // next accepted pixel; rows 0-1 may see stale data but never reach a window.
  sobel_line_buf #(.DEPTH(IMG_W), .DW(PIX_W)) u_lb0 (
    .clk       (clk),
    .i_en      (w_accept),
    .i_wr_addr (w_col),
    .i_wr_data (pix_in),
    .i_rd_addr (w_col_nxt),
    .o_rd_data (w_lb0_q)
  );

  sobel_line_buf #(.DEPTH(IMG_W), .DW(PIX_W)) u_lb1 (
    .clk       (clk),
    .i_en      (w_accept),
    .i_wr_addr (w_col),
    .i_wr_data (w_lb0_q),
    .i_rd_addr (w_col_nxt),
    .o_rd_data (w_lb1_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win <= '0;
    end else if (w_accept) begin
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
      end
      r_win[0][2] <= w_lb1_q;
      r_win[1][2] <= w_lb0_q;
      r_win[2][2] <= pix_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_valid   <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_abort <= 1'b0;
    end else begin
      r_win_valid   <= w_accept && (w_row >= RW'(2)) && (w_col >= CW'(2));
      r_frame_done  <= w_accept && w_frame_end;
      r_frame_abort <= w_restart && (r_state != IDLE);
    end
  end

  assign p0 = r_win[0][0];
  assign p1 = r_win[0][1];
  assign p2 = r_win[0][2];
  assign p3 = r_win[1][0];
`ifdef SOBEL_WIN_CENTER_EN
  assign p4 = r_win[1][1];
`endif
  assign p5 = r_win[1][2];
  assign p6 = r_win[2][0];
  assign p7 = r_win[2][1];
  assign p8 = r_win[2][2];

  assign win_valid   = r_win_valid;
  assign frame_done  = r_frame_done;
  assign frame_abort = r_frame_abort;

endmodule

`default_nettype wire

// File: tb/tb_sobel_window_gen.sv
// +----------------------------------------------------------------------------+
// | tb_sobel_window_gen: random and directed frames against an image model.     |
// | Revision: 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sobel_window_gen;

  localparam int W = 4;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sof = 1'b0;
  logic pix_valid = 1'b0;
  logic [7:0] pix_in = '0;
  logic [7:0] p0, p1, p2, p3, p5, p6, p7, p8;
  logic win_valid, frame_done, frame_abort;
  logic [71:0] act;
`ifdef SOBEL_WIN_CENTER_EN
  logic [7:0] p4;
  assign act = {p0, p1, p2, p3, p4, p5, p6, p7, p8};
`else
  assign act = {p0, p1, p2, p3, 8'h00, p5, p6, p7, p8};
`endif

  sobel_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sof         (sof),
    .pix_valid   (pix_valid),
    .pix_in      (pix_in),
    .p0          (p0),
    .p1          (p1),
    .p2          (p2),
    .p3          (p3),
`ifdef SOBEL_WIN_CENTER_EN
    .p4          (p4),
`endif
    .p5          (p5),
    .p6          (p6),
    .p7          (p7),
    .p8          (p8),
    .win_valid   (win_valid),
    .frame_done  (frame_done),
    .frame_abort (frame_abort)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  int n_done_seen = 0;

  // Image model: position inside the frame plus the pixels received so far.
  logic [7:0] img [0:H-1][0:W-1];
  bit in_frame = 1'b0;
  int mr = 0;
  int mc = 0;
  logic e_wv = 1'b0;
  logic e_done = 1'b0;
  logic e_abort = 1'b0;
  logic [71:0] e_win = '0;

  task automatic chk(input string nm, input logic [71:0] a, input logic [71:0] e);
    n_checks++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic logic [71:0] vis(input logic [71:0] e);
`ifdef SOBEL_WIN_CENTER_EN
    return e;
`else
    return {e[71:40], 8'h00, e[31:0]};
`endif
  endfunction

  task automatic model_reset();
    in_frame = 1'b0;
    mr = 0;
    mc = 0;
    e_wv = 1'b0;
    e_done = 1'b0;
    e_abort = 1'b0;
  endtask

  // Drive one cycle and predict what the DUT shows after the next rising edge.
  task automatic step(input bit pv, input bit s, input logic [7:0] px);
    @(negedge clk);
    pix_valid = pv;
    sof = s;
    pix_in = px;
    e_wv = 1'b0;
    e_done = 1'b0;
    e_abort = 1'b0;
    if (pv) begin
      if (s) begin
        e_abort = in_frame;
        in_frame = 1'b1;
        mr = 0;
        mc = 0;
      end
      if (in_frame) begin
        img[mr][mc] = px;
        if (mr >= 2 && mc >= 2) begin
          e_wv = 1'b1;
          e_win = {img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc],
                   img[mr-1][mc-2], img[mr-1][mc-1], img[mr-1][mc],
                   img[mr][mc-2],   img[mr][mc-1],   img[mr][mc]};
        end
        if (mr == H-1 && mc == W-1) begin
          e_done = 1'b1;
          in_frame = 1'b0;
          mr = 0;
          mc = 0;
        end else if (mc == W-1) begin
          mc = 0;
          mr++;
        end else begin
          mc++;
        end
      end
    end
  endtask

  task automatic send(input bit s, input logic [7:0] px, input int duty);
    while ($urandom_range(99, 0) >= duty) step(1'b0, 1'b0, 8'($urandom));
    step(1'b1, s, px);
  endtask

  task automatic frame(input int duty, input bit ramp);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send(r == 0 && c == 0, ramp ? 8'(r*16 + c) : 8'($urandom), duty);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    pix_valid = 1'b0;
    sof = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    chk("win_valid", {71'd0, win_valid}, {71'd0, e_wv});
    chk("frame_done", {71'd0, frame_done}, {71'd0, e_done});
    chk("frame_abort", {71'd0, frame_abort}, {71'd0, e_abort});
    if (e_wv) chk("window", act, vis(e_win));
    if (frame_done) n_done_seen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int d0;
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_taps", act, 72'h0);
    chk("reset_strobes", {69'd0, win_valid, frame_done, frame_abort}, 72'h0);
    rst_n = 1'b1;

    // Continuous ramp frame with literal first/last windows
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send(r == 0 && c == 0, 8'(r*16 + c), 100);
        if (r == 2 && c == 2) begin
          @(posedge clk); #2;
          chk("first_window", {8'h00, p0, p1, p2, p3, p5, p6, p7, p8},
              72'h00_0001021012202122);
`ifdef SOBEL_WIN_CENTER_EN
          chk("first_p4", {64'd0, p4}, 72'h11);
`endif
        end
      end
    end
    @(posedge clk); #2;
    chk("last_window", {8'h00, p0, p1, p2, p3, p5, p6, p7, p8},
        72'h00_1112132123313233);
    chk("last_frame_done", {71'd0, frame_done}, 72'h1);
`ifdef SOBEL_WIN_CENTER_EN
    chk("last_p4", {64'd0, p4}, 72'h22);
`endif
    idle(3);

    // Same frame with gaps
    frame(50, 1'b1);
    idle(3);

    // Pixels without sof after reset are dropped
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'($urandom));
    d0 = n_done_seen;
    frame(100, 1'b1);
    idle(2);
    chk("done_after_sofless", 72'(n_done_seen - d0), 72'd1);

    // sof at pixel (2,1) aborts and restarts
    for (int i = 0; i < 9; i++) send(i == 0, 8'(((i / W) * 16) + (i % W)), 100);
    d0 = n_done_seen;
    send(1'b1, 8'h00, 100);
    @(posedge clk); #2;
    chk("abort_pulse", {71'd0, frame_abort}, 72'h1);
    for (int i = 1; i < W*H; i++) send(1'b0, 8'(((i / W) * 16) + (i % W)), 100);
    idle(2);
    chk("done_after_abort", 72'(n_done_seen - d0), 72'd1);

    // Asynchronous reset at pixel (3,0)
    for (int i = 0; i < 13; i++) send(i == 0, 8'(((i / W) * 16) + (i % W)), 100);
    @(posedge clk); #3;
    rst_n = 1'b0;
    pix_valid = 1'b0;
    sof = 1'b0;
    model_reset();
    #1;
    chk("async_rst_taps", act, 72'h0);
    chk("async_rst_strobes", {69'd0, win_valid, frame_done, frame_abort}, 72'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    frame(100, 1'b1);
    idle(2);

    // Random frames, random gaps, stray sof-less pixels and random aborts
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < int'($urandom_range(3, 0)); i++) step(1'b1, 1'b0, 8'($urandom));
      for (int i = 0; i < W*H; i++) begin
        bit s;
        s = (i == 0) || ($urandom_range(29, 0) == 0);
        send(s, 8'($urandom), 60);
      end
      idle(int'($urandom_range(2, 0)));
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Streaming 3x3 window generator; producer side of the Sobel convolution's p0..p8 pixel interface.
- Accepts a raster-order 8-bit grayscale pixel stream, buffers two previous lines, and presents a registered 3x3 neighbourhood plus a valid strobe.
- Sits between the camera/grayscale front end and the combinational Sobel kernel.

Parameters:
- IMG_W, 640, active pixels per line (>=3).
- IMG_H, 480, active lines per frame (>=3).
- PIX_W, 8, pixel width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sof  in  1  start of frame; qualified by pix_valid; marks pixel (0,0).
- pix_valid  in  1  input pixel strobe; gaps allowed, no backpressure.
- pix_in  in  PIX_W  grayscale pixel.
- p0,p1,p2  out  PIX_W  top window row (line r-2), columns c-2,c-1,c.
- p3,p5  out  PIX_W  middle row (line r-1), columns c-2,c.
- p6,p7,p8  out  PIX_W  bottom row (line r), columns c-2,c-1,c.
- win_valid  out  1  window strobe, centre at (r-1,c-1).
- frame_done  out  1  one-cycle pulse with the last window of a frame.
- frame_abort  out  1  one-cycle pulse when sof arrives mid-frame.

Behaviour:
- Reset: all outputs 0; col=0, row=0; state IDLE; line-buffer contents don't-care.
- FSM states: IDLE, FILL, STREAM.
  - IDLE -> FILL on pix_valid&&sof. Pixels without sof in IDLE are dropped.
  - FILL -> STREAM when the pixel at (1,IMG_W-1) is accepted.
  - STREAM -> IDLE when the pixel at (IMG_H-1,IMG_W-1) is accepted.
- Counters:
  - col increments on each accepted pixel and wraps IMG_W-1 -> 0, incrementing row.
  - row wraps only via the return to IDLE.
  - Widths are $clog2 of the maximum.
- Line buffers:
  - Two single-port-per-cycle buffers of depth IMG_W, addressed by col.
  - On an accepted pixel, read lb0[col] and lb1[col] (line r-1 and r-2 data), then write lb1[col] <= lb0[col] and lb0[col] <= pix_in.
- Window shift:
  - Each accepted pixel shifts all three rows left by one column.
  - New column is {lb1 out, lb0 out, pix_in} into {p2,p5,p8}.
  - p4 is held internally (middle-row centre), not exported.
- win_valid is registered: it asserts the cycle after an accepted pixel with row>=2 && col>=2. Latency is 1 clk from pix_valid to window.
- With no pix_valid, all state and outputs hold and win_valid=0.
- Border windows (row<2 or col<2) are never emitted. Exactly (IMG_W-2)*(IMG_H-2) windows per frame.
- frame_done asserts in the same cycle as win_valid for centre (IMG_H-2,IMG_W-2).
- sof with pix_valid in FILL or STREAM:
  - Pulse frame_abort.
  - Restart at (0,0) with that pixel as the first of the new frame; state FILL.
  - Stale line-buffer data is overwritten before use.
- rst_n low mid-frame: immediate return to reset state; no frame_done.

Optional Feature:
- Macro SOBEL_WIN_CENTER_EN.
- Defined: adds output port p4 (PIX_W), middle row column c-1, registered with the other taps.
- Undefined: no p4 port; the centre tap is still stored internally for the shift chain (synthesis may prune it).

Decomposition:
- sobel_pkg holds:
  - PIX_W default constant.
  - win_state_e enum {IDLE, FILL, STREAM}.
  - pix_t typedef.
  - 3x3 window struct for internal use.
- Sub-module sobel_line_buf: one IMG_W x PIX_W buffer with registered read and same-address write.
- Top instantiates it twice, plus the counters, FSM and 3x3 register array.

Test Plan:
- IMG_W=4, IMG_H=4, pixel = row*16+col, continuous valid -> 4 windows.
  - First window: p0..p8 = 00,01,02,10,12,20,21,22.
  - Last window: 11,12,13,21,23,31,32,33, with frame_done on that cycle.
- Same frame with a random 50% pix_valid duty -> identical window sequence; win_valid only 1 clk after accepted pixels.
- Pixels without sof after reset -> no windows. Then a frame with sof -> normal 4 windows.
- sof at pixel (2,1) of a 4x4 frame -> frame_abort pulse; the next full 4x4 frame yields its correct 4 windows and one frame_done.
- rst_n asserted at pixel (3,0) -> all outputs 0 asynchronously; a subsequent clean frame is correct.
- SOBEL_WIN_CENTER_EN build, 4x4 ramp -> p4 = 11,12,21,22 on the four windows.
